// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: one instruction in flight, variable-latency dmem port, one writeback beat per op
// Optional MEM_ALIGN_CHECK_EN: misaligned LOAD/STORE retires without a dmem request and sets sticky misalign_po.
module mem_stage #(
   parameter int REG_AW = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk_pi,
   input  logic              rst_n_pi,
   input  logic              in_valid_pi,
   output logic              in_ready_po,
   input  logic [5:0]        aluFunc_pi,
   input  logic [DATA_W-1:0] aluResult_pi,
   input  logic [DATA_W-1:0] storeData_pi,
   input  logic [REG_AW-1:0] dest_pi,
   output logic              dmem_req_po,
   output logic              dmem_we_po,
   output logic [DATA_W-1:0] dmem_addr_po,
   output logic [DATA_W-1:0] dmem_wdata_po,
   input  logic              dmem_ack_pi,
   input  logic [DATA_W-1:0] dmem_rdata_pi,
   output logic              wb_valid_po,
   output logic              wb_we_po,
   output logic [REG_AW-1:0] wb_dest_po,
   output logic [DATA_W-1:0] wb_data_po,
   output logic              halt_po,
   output logic              misalign_po
);

   localparam logic [5:0] OP_ADD   = 6'd1;
   localparam logic [5:0] OP_LOAD  = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd5;
   localparam logic [5:0] OP_STORE = 6'd6;
   localparam logic [5:0] OP_HALT  = 6'd10;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HALTED} state_t;

   state_t              state;
   logic                is_load_q;
   logic [REG_AW-1:0]   dest_q;
   logic                accept;
   logic                is_mem;
   logic                misaligned;
   logic [DATA_W-1:0]   addr_aligned;

   // Gated by reset so execute never sees a ready stage while the pipeline is held in reset.
   assign in_ready_po  = rst_n_pi && (state == S_IDLE);
   assign accept       = in_valid_pi && in_ready_po;
   assign is_mem       = (aluFunc_pi == OP_LOAD) || (aluFunc_pi == OP_STORE);
   assign addr_aligned = {aluResult_pi[DATA_W-1:2], 2'b00};

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = (aluResult_pi[1:0] != 2'b00);

   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi)
         misalign_po <= 1'b0;
      else if (accept && is_mem && misaligned)
         misalign_po <= 1'b1;
   end
`else
   assign misaligned  = 1'b0;
   assign misalign_po = 1'b0;
`endif

   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
         state         <= S_IDLE;
         dmem_req_po   <= 1'b0;
         dmem_we_po    <= 1'b0;
         dmem_addr_po  <= '0;
         dmem_wdata_po <= '0;
         wb_valid_po   <= 1'b0;
         wb_we_po      <= 1'b0;
         wb_dest_po    <= '0;
         wb_data_po    <= '0;
         halt_po       <= 1'b0;
         is_load_q     <= 1'b0;
         dest_q        <= '0;
      end else begin
         wb_valid_po <= 1'b0;
         wb_we_po    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (is_mem && !misaligned) begin
                     state         <= S_ACCESS;
                     dmem_req_po   <= 1'b1;
                     dmem_we_po    <= (aluFunc_pi == OP_STORE);
                     dmem_addr_po  <= addr_aligned;
                     dmem_wdata_po <= storeData_pi;
                     is_load_q     <= (aluFunc_pi == OP_LOAD);
                     dest_q        <= dest_pi;
                  end else begin
                     // Non-memory ops and trapped misaligned accesses retire straight from IDLE.
                     wb_valid_po <= 1'b1;
                     wb_dest_po  <= dest_pi;
                     wb_data_po  <= aluResult_pi;
                     wb_we_po    <= ((aluFunc_pi == OP_ADD) || (aluFunc_pi == OP_ADDI)) && (dest_pi != '0);
                     if (aluFunc_pi == OP_HALT) begin
                        halt_po <= 1'b1;
                        state   <= S_HALTED;
                     end
                  end
               end
            end
            S_ACCESS: begin
               if (dmem_ack_pi) begin
                  state       <= S_IDLE;
                  dmem_req_po <= 1'b0;
                  wb_valid_po <= 1'b1;
                  wb_dest_po  <= dest_q;
                  wb_data_po  <= is_load_q ? dmem_rdata_pi : dmem_addr_po;
                  wb_we_po    <= is_load_q && (dest_q != '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
